// File: rtl/complex_sqrt_if.sv
// Handshake and data bundle for the complex square-root block.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the sample side, out_valid/out_ready on the result side.
//
// Ports (slave = the square-root block):
//   in_valid, sReal, sImag, out_ready : driven by the master
//   in_ready, out_valid, rReal, rImag : driven by the slave
interface complex_sqrt_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sReal;
    logic [WIDTH-1:0] sImag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] rReal;
    logic [WIDTH-1:0] rImag;

    modport slave (
        input  in_valid,
        input  sReal,
        input  sImag,
        input  out_ready,
        output in_ready,
        output out_valid,
        output rReal,
        output rImag
    );

    modport master (
        output in_valid,
        output sReal,
        output sImag,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  rReal,
        input  rImag
    );
endinterface

// File: rtl/complex_sqrt.sv
// Principal complex square root of one signed sample using one shared bit-serial isqrt engine.
// Latency: out_valid rises 3*WIDTH+3 edges after the accepting edge; one operation in flight.
// Backpressure: in_ready only in IDLE; result held with out_valid high until out_ready.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   io   : complex_sqrt_if.slave -- sample in (in_valid/in_ready, sReal, sImag),
//          result out (out_valid/out_ready, rReal >= 0, rImag two's complement)
// Build option: define COMPLEX_SQRT_ROUND_EN to round the x and y passes to nearest
// (the magnitude pass always floors). Latency is the same either way.
module complex_sqrt #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    complex_sqrt_if.slave io
);

    localparam int W   = WIDTH;
    localparam int CW  = $clog2(WIDTH);
    // Working remainder during a step: previous remainder plus two radicand bits.
    localparam int RW  = WIDTH + 3;
    // Stored remainder: bounded by 2*root, so one bit wider than the root.
    localparam int RMW = WIDTH + 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] MAG    = 3'd1;
    localparam logic [2:0] ROOT_M = 3'd2;
    localparam logic [2:0] PREP   = 3'd3;
    localparam logic [2:0] ROOT_X = 3'd4;
    localparam logic [2:0] ROOT_Y = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    logic [2:0]     state_q,     state_d;
    logic [CW-1:0]  cnt_q,       cnt_d;
    logic [W-1:0]   a_q,         a_d;
    logic [W-1:0]   b_q,         b_d;
    logic [W-1:0]   mag_q,       mag_d;
    logic [W-1:0]   py_q,        py_d;
    logic [W-1:0]   x_q,         x_d;
    logic [2*W-1:0] rad_q,       rad_d;
    logic [RMW-1:0] rem_q,       rem_d;
    logic [W-1:0]   root_q,      root_d;
    logic [W-1:0]   r_real_q,    r_real_d;
    logic [W-1:0]   r_imag_q,    r_imag_d;
    logic           out_valid_q, out_valid_d;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic signed [2*W-1:0] a_ext;
    logic signed [2*W-1:0] b_ext;
    logic [2*W-1:0]        sum_sq;
    logic [W:0]            mag_ext;
    logic [W:0]            a_sx;
    logic [W-1:0]          px;
    logic [W-1:0]          py;

    always_comb begin
        a_ext  = {{W{a_q[W-1]}}, a_q};
        b_ext  = {{W{b_q[W-1]}}, b_q};
        // Each square is at most 2^(2W-2), so the sum fits 2W bits unsigned.
        sum_sq = $unsigned(a_ext * a_ext) + $unsigned(b_ext * b_ext);

        // mag >= |a|, so both (mag + a) and (mag - a) lie in [0, 2^(W+1)) and the
        // W+1-bit modular result is exact; the shift brings them back to W bits.
        mag_ext = {1'b0, mag_q};
        a_sx    = {a_q[W-1], a_q};
        px      = W'((mag_ext + a_sx) >> 1);
        py      = W'((mag_ext - a_sx) >> 1);
    end

    // ------------------------------------------------------------------
    // Restoring isqrt step: bring down two radicand bits, try (4*root + 1).
    // ------------------------------------------------------------------
    logic [RW-1:0]  rem_sh;
    logic [RW-1:0]  trial;
    logic           take;
    logic [RMW-1:0] rem_nxt;
    logic [W-1:0]   root_nxt;
    logic [2*W-1:0] rad_nxt;
    logic [W-1:0]   res_fin;
    logic           last;

    always_comb begin
        rem_sh   = {rem_q, rad_q[2*W-1 -: 2]};
        trial    = {1'b0, root_q, 2'b01};
        take     = (rem_sh >= trial);
        rem_nxt  = RMW'(take ? (rem_sh - trial) : rem_sh);
        root_nxt = {root_q[W-2:0], take};
        rad_nxt  = {rad_q[2*W-3:0], 2'b00};
        last     = (cnt_q == CW'(WIDTH - 1));
    end

    // Final value of the x / y passes as seen on their last iteration.
`ifdef COMPLEX_SQRT_ROUND_EN
    // Round to nearest: radicand - q^2 > q means the radicand is past (q + 0.5)^2.
    always_comb begin
        res_fin = (rem_nxt > {1'b0, root_nxt}) ? (root_nxt + W'(1)) : root_nxt;
    end
`else
    always_comb begin
        res_fin = root_nxt;
    end
`endif

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        mag_d       = mag_q;
        py_d        = py_q;
        x_d         = x_q;
        rad_d       = rad_q;
        rem_d       = rem_q;
        root_d      = root_q;
        r_real_d    = r_real_q;
        r_imag_d    = r_imag_q;
        out_valid_d = out_valid_q;

        // The engine advances in every root pass; loads below override it.
        if (state_q == ROOT_M || state_q == ROOT_X || state_q == ROOT_Y) begin
            rad_d  = rad_nxt;
            rem_d  = rem_nxt;
            root_d = root_nxt;
            cnt_d  = last ? '0 : (cnt_q + CW'(1));
        end

        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    a_d     = io.sReal;
                    b_d     = io.sImag;
                    state_d = MAG;
                end
            end
            MAG: begin
                rad_d   = sum_sq;
                rem_d   = '0;
                root_d  = '0;
                cnt_d   = '0;
                state_d = ROOT_M;
            end
            ROOT_M: begin
                if (last) begin
                    mag_d   = root_nxt;
                    state_d = PREP;
                end
            end
            PREP: begin
                rad_d   = {{W{1'b0}}, px};
                rem_d   = '0;
                root_d  = '0;
                cnt_d   = '0;
                py_d    = py;
                state_d = ROOT_X;
            end
            ROOT_X: begin
                if (last) begin
                    x_d     = res_fin;
                    rad_d   = {{W{1'b0}}, py_q};
                    rem_d   = '0;
                    root_d  = '0;
                    state_d = ROOT_Y;
                end
            end
            ROOT_Y: begin
                if (last) begin
                    r_real_d = x_q;
                    // b == 0 with a < 0 lands here with the sign bit clear: +j*y.
                    r_imag_d = b_q[W-1] ? ('0 - res_fin) : res_fin;
                    state_d  = DONE;
                end
            end
            DONE: begin
                // The result registers settle on DONE entry; out_valid follows one
                // edge later and drops on the transfer edge.
                if (out_valid_q && io.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mag_q       <= '0;
            py_q        <= '0;
            x_q         <= '0;
            rad_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            r_real_q    <= '0;
            r_imag_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mag_q       <= mag_d;
            py_q        <= py_d;
            x_q         <= x_d;
            rad_q       <= rad_d;
            rem_q       <= rem_d;
            root_q      <= root_d;
            r_real_q    <= r_real_d;
            r_imag_q    <= r_imag_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = out_valid_q;
    assign io.rReal     = r_real_q;
    assign io.rImag     = r_imag_q;

endmodule

// File: tb/tb_complex_sqrt.sv
// Directed bench for complex_sqrt: hand-computed roots, latency, backpressure, mid-op reset.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low with a pending new sample.
module tb_complex_sqrt;

    localparam int W = 16;
    localparam int LAT = 3 * W + 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    complex_sqrt_if #(.WIDTH(W)) dif();

    complex_sqrt #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (dif)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int bad_rdy = 0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts edges after the accept edge until out_valid is seen; notes any
    // cycle where in_ready was not low while busy.
    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (dif.out_valid !== 1'b1 && dif.in_ready !== 1'b0) bad_rdy++;
        end while (dif.out_valid !== 1'b1 && n < 200);
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        @(negedge clk);
        dif.sReal    = a;
        dif.sImag    = b;
        dif.in_valid = 1'b1;
        check({tag, ".in_ready"}, dif.in_ready, 1);
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
    endtask

    task automatic finish_op(input string tag, input int er, input int ei);
        int n;
        bad_rdy = 0;
        wait_out(n);
        check({tag, ".latency"}, n, LAT);
        check({tag, ".busy_rdy"}, bad_rdy, 0);
        check({tag, ".rReal"}, dif.rReal, er);
        check({tag, ".rImag"}, $signed(dif.rImag), ei);
    endtask

    // With out_ready high the transfer happens on the next edge.
    task automatic handshake(input string tag);
        @(negedge clk);
        check({tag, ".ov_after"}, dif.out_valid, 0);
        check({tag, ".rdy_after"}, dif.in_ready, 1);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int er, input int ei, input string tag);
        start_op(a, b, tag);
        finish_op(tag, er, ei);
        handshake(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp8;
        rst           = 1'b0;
        dif.in_valid  = 1'b0;
        dif.sReal     = '0;
        dif.sImag     = '0;
        dif.out_ready = 1'b1;

        #12;
        check("reset.in_ready", dif.in_ready, 1);
        check("reset.out_valid", dif.out_valid, 0);
        check("reset.rReal", dif.rReal, 0);
        check("reset.rImag", $signed(dif.rImag), 0);
        @(negedge clk);
        rst = 1'b1;

        // Main function
        do_op(-16'sd7, 16'sd24, 3, 4, "m7p24");
        do_op(-16'sd7, -16'sd24, 3, -4, "m7m24");
        do_op(16'sd16, 16'sd0, 4, 0, "p16");
        do_op(-16'sd16, 16'sd0, 0, 4, "m16");
        do_op(16'sd0, 16'sd0, 0, 0, "zero");
        do_op(16'sd3, 16'sd4, 2, 1, "p3p4");
        do_op(16'sd5, -16'sd12, 3, -2, "p5m12");
        do_op(16'sh8000, 16'sd0, 0, 181, "min");
`ifdef COMPLEX_SQRT_ROUND_EN
        exp8 = 3;
`else
        exp8 = 2;
`endif
        do_op(16'sd8, 16'sd0, exp8, 0, "p8");

        // Backpressure with a new sample waiting
        dif.out_ready = 1'b0;
        start_op(-16'sd7, 16'sd24, "bp");
        finish_op("bp", 3, 4);
        for (int i = 0; i < 10; i++) begin
            dif.sReal    = 16'sd16;
            dif.sImag    = 16'sd0;
            dif.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("bp.hold_ov", dif.out_valid, 1);
            check("bp.hold_rdy", dif.in_ready, 0);
            check("bp.hold_rReal", dif.rReal, 3);
            check("bp.hold_rImag", $signed(dif.rImag), 4);
        end
        dif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp.after_ov", dif.out_valid, 0);
        check("bp.after_rdy", dif.in_ready, 1);
        // in_valid still high: this edge is the one that accepts the waiting sample.
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
        finish_op("bp_next", 4, 0);
        handshake("bp_next");

        // Reset in the middle of ROOT_X
        start_op(-16'sd7, 16'sd24, "rst");
        repeat (24) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.out_valid", dif.out_valid, 0);
        check("rst.rReal", dif.rReal, 0);
        check("rst.rImag", $signed(dif.rImag), 0);
        check("rst.in_ready", dif.in_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst.idle_rdy", dif.in_ready, 1);
        check("rst.idle_ov", dif.out_valid, 0);
        do_op(16'sd16, 16'sd0, 4, 0, "post_rst");

        n = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
